// File: rtl/palette_fader_if.sv
// Palette fader bus: level selection, palette-table writes, pixel lookup
// and the displayed-colour outputs, bundled for the fader and its host.
interface palette_fader_if #(
    parameter int LEVELS  = 8,
    parameter int NCOLORS = 4,
    parameter int CH_W    = 4
);
    localparam int CW = 3 * CH_W;
    localparam int LW = $clog2(LEVELS);
    localparam int IW = $clog2(NCOLORS);

    logic [LW-1:0]         LEVEL;
    logic                  FADE_EN;
    logic                  WR_EN;
    logic [LW-1:0]         WR_LEVEL;
    logic [IW-1:0]         WR_INDEX;
    logic [CW-1:0]         WR_DATA;
    logic [IW-1:0]         PIX_INDEX;
    logic [CW-1:0]         PIX_COLOR;
    logic [NCOLORS*CW-1:0] COLORS;
    logic [LW-1:0]         CUR_LEVEL;
    logic                  BUSY;

    // Host side: selects levels, writes the table, looks up pixels.
    modport master (
        output LEVEL, FADE_EN, WR_EN, WR_LEVEL, WR_INDEX, WR_DATA, PIX_INDEX,
        input  PIX_COLOR, COLORS, CUR_LEVEL, BUSY
    );

    // Fader side.
    modport slave (
        input  LEVEL, FADE_EN, WR_EN, WR_LEVEL, WR_INDEX, WR_DATA, PIX_INDEX,
        output PIX_COLOR, COLORS, CUR_LEVEL, BUSY
    );
endinterface

// File: rtl/palette_fader.sv
// Palette fader: a writable LEVELS x NCOLORS colour table and a set of
// displayed colours that either snap to a newly selected palette or walk
// toward it one channel unit per STEP_DIV cycles.
module palette_fader #(
    parameter int LEVELS   = 8,
    parameter int NCOLORS  = 4,
    parameter int CH_W     = 4,
    parameter int STEP_DIV = 4
) (
    input  logic           CLK,
    input  logic           RESET_N,
    palette_fader_if.slave bus
);
    localparam int CW = 3 * CH_W;
    localparam int LW = $clog2(LEVELS);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic {IDLE, FADE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cur_level_q, cur_level_d;
    logic [LW-1:0]   target_q, target_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   disp_q [NCOLORS];
    logic [CW-1:0]   disp_d [NCOLORS];
    logic [CW-1:0]   stepped [NCOLORS];
    logic [CW-1:0]   tbl_q [LEVELS][NCOLORS];
    logic [CW-1:0]   pix_q;
    logic [NCOLORS*CW-1:0] colors_flat;
    logic            all_match;
    logic            step_wrap;

    // Power-up palette contents; the reference 8x4x4 configuration has a
    // fixed set of hand-picked colours, anything else gets black plus white.
    function automatic logic [CW-1:0] default_entry(input int lvl, input int idx);
        logic [11:0] e12;
        e12 = 12'h000;
        if (LEVELS == 8 && NCOLORS == 4 && CH_W == 4 && idx < 2) begin
            case (lvl * 2 + idx)
                0:  e12 = 12'h4cf;  1: e12 = 12'h05f;
                2:  e12 = 12'h8d0;  3: e12 = 12'h0a0;
                4:  e12 = 12'hf7f;  5: e12 = 12'he0d;
                6:  e12 = 12'h6e6;  7: e12 = 12'h06f;
                8:  e12 = 12'h6fa;  9: e12 = 12'hf06;
                10: e12 = 12'h5f9; 11: e12 = 12'h78f;
                12: e12 = 12'hf30; 13: e12 = 12'h888;
                14: e12 = 12'h74f; 15: e12 = 12'hb02;
                default: e12 = 12'h000;
            endcase
            return CW'(e12);
        end
        return (idx == NCOLORS - 1) ? '1 : '0;
    endfunction

    // Move each channel one unit toward the target channel; equal holds.
    function automatic logic [CW-1:0] step_toward(input logic [CW-1:0] cur,
                                                   input logic [CW-1:0] tgt);
        logic [CW-1:0] res;
        res = cur;
        for (int c = 0; c < 3; c++) begin
            if (cur[c*CH_W +: CH_W] < tgt[c*CH_W +: CH_W])
                res[c*CH_W +: CH_W] = cur[c*CH_W +: CH_W] + CH_W'(1);
            else if (cur[c*CH_W +: CH_W] > tgt[c*CH_W +: CH_W])
                res[c*CH_W +: CH_W] = cur[c*CH_W +: CH_W] - CH_W'(1);
        end
        return res;
    endfunction

    // Palette table: reset to defaults, written by the host strobe.
    // NOTE: the table is reset on purpose -- it must come up with known
    // palettes and lose pre-reset writes, so it cannot map onto a RAM macro.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int l = 0; l < LEVELS; l++)
                for (int i = 0; i < NCOLORS; i++)
                    tbl_q[l][i] <= default_entry(l, i);
        end else if (bus.WR_EN) begin
            tbl_q[bus.WR_LEVEL][bus.WR_INDEX] <= bus.WR_DATA;
        end
    end

    // Candidate next displayed colours one step closer to the target.
    always_comb begin
        all_match = 1'b1;
        for (int i = 0; i < NCOLORS; i++) begin
            stepped[i] = step_toward(disp_q[i], tbl_q[target_q][i]);
            if (stepped[i] != tbl_q[target_q][i])
                all_match = 1'b0;
        end
    end

    assign step_wrap = (step_q == SW'(STEP_DIV - 1));

    // Next-state and datapath control for the IDLE/FADE controller.
    // NOTE: every output is given its hold value first so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cur_level_d = cur_level_q;
        target_d    = target_q;
        step_d      = step_q;
        for (int i = 0; i < NCOLORS; i++)
            disp_d[i] = disp_q[i];

        case (state_q)
            IDLE: begin
                for (int i = 0; i < NCOLORS; i++)
                    disp_d[i] = tbl_q[cur_level_q][i];
                if (bus.LEVEL != cur_level_q) begin
                    if (bus.FADE_EN) begin
                        target_d = bus.LEVEL;
                        step_d   = '0;
                        state_d  = FADE;
                    end else begin
                        cur_level_d = bus.LEVEL;
                        for (int i = 0; i < NCOLORS; i++)
                            disp_d[i] = tbl_q[bus.LEVEL][i];
                    end
                end
            end
            FADE: begin
                if (!bus.FADE_EN) begin
                    // Fading switched off: jump straight to the target.
                    cur_level_d = target_q;
                    step_d      = '0;
                    state_d     = IDLE;
                    for (int i = 0; i < NCOLORS; i++)
                        disp_d[i] = tbl_q[target_q][i];
                end else begin
                    step_d = step_wrap ? '0 : step_q + SW'(1);
                    if (step_wrap)
                        for (int i = 0; i < NCOLORS; i++)
                            disp_d[i] = stepped[i];
                    if (bus.LEVEL != target_q) begin
                        // Retarget keeps the colours and step phase as-is.
                        target_d = bus.LEVEL;
                    end else if (step_wrap && all_match) begin
                        cur_level_d = target_q;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Committed level, fade target, step phase and displayed colours.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cur_level_q <= '0;
            target_q    <= '0;
            step_q      <= '0;
            for (int i = 0; i < NCOLORS; i++)
                disp_q[i] <= default_entry(0, i);
        end else begin
            cur_level_q <= cur_level_d;
            target_q    <= target_d;
            step_q      <= step_d;
            for (int i = 0; i < NCOLORS; i++)
                disp_q[i] <= disp_d[i];
        end
    end

    // Registered pixel lookup into the displayed colours.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pix_q <= '0;
        else          pix_q <= disp_q[bus.PIX_INDEX];
    end

    // Flatten displayed colours onto the bus, index i at [i*CW +: CW].
    always_comb begin
        colors_flat = '0;
        for (int i = 0; i < NCOLORS; i++)
            colors_flat[i*CW +: CW] = disp_q[i];
    end

    assign bus.COLORS    = colors_flat;
    assign bus.PIX_COLOR = pix_q;
    assign bus.CUR_LEVEL = cur_level_q;
    assign bus.BUSY      = (state_q == FADE);
endmodule

// File: tb/tb_palette_fader.sv
// Bench for palette_fader: a behavioural palette model checked against the
// DUT every cycle, plus hand-computed expectations at key points.
module tb_palette_fader;
    localparam int LEVELS   = 8;
    localparam int NCOLORS  = 4;
    localparam int CH_W     = 4;
    localparam int STEP_DIV = 4;
    localparam int CW       = 12;

    localparam logic [11:0] RST_C0 [8] = '{12'h4cf, 12'h8d0, 12'hf7f, 12'h6e6,
                                           12'h6fa, 12'h5f9, 12'hf30, 12'h74f};
    localparam logic [11:0] RST_C1 [8] = '{12'h05f, 12'h0a0, 12'he0d, 12'h06f,
                                           12'hf06, 12'h78f, 12'h888, 12'hb02};

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    palette_fader_if #(.LEVELS(LEVELS), .NCOLORS(NCOLORS), .CH_W(CH_W)) bus();

    palette_fader #(.LEVELS(LEVELS), .NCOLORS(NCOLORS), .CH_W(CH_W),
                    .STEP_DIV(STEP_DIV)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] m_tbl [LEVELS][NCOLORS];
    logic [11:0] m_disp [NCOLORS];
    logic [11:0] m_pix;
    int          m_cur, m_target, m_fade_cycles;
    bit          m_busy;

    function automatic logic [11:0] toward(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        int x, y;
        r = a;
        for (int ch = 0; ch < 3; ch++) begin
            x = int'(a[ch*4 +: 4]);
            y = int'(b[ch*4 +: 4]);
            x = x + ((y > x) ? 1 : (y < x) ? -1 : 0);
            r[ch*4 +: 4] = 4'(x);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LEVELS; l++) begin
            m_tbl[l][0] = RST_C0[l];
            m_tbl[l][1] = RST_C1[l];
            m_tbl[l][2] = 12'h000;
            m_tbl[l][3] = 12'hfff;
        end
        for (int i = 0; i < NCOLORS; i++) m_disp[i] = m_tbl[0][i];
        m_pix = 12'h000;
        m_cur = 0;
        m_target = 0;
        m_fade_cycles = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_step();
        int lvl;
        bit at_step, done;
        lvl = int'(bus.LEVEL);
        m_pix = m_disp[bus.PIX_INDEX];
        if (!m_busy) begin
            if (lvl != m_cur && !bus.FADE_EN) m_cur = lvl;
            for (int i = 0; i < NCOLORS; i++) m_disp[i] = m_tbl[m_cur][i];
            if (lvl != m_cur) begin
                m_busy = 1'b1;
                m_target = lvl;
                m_fade_cycles = 0;
            end
        end else if (!bus.FADE_EN) begin
            m_cur = m_target;
            for (int i = 0; i < NCOLORS; i++) m_disp[i] = m_tbl[m_cur][i];
            m_busy = 1'b0;
        end else begin
            m_fade_cycles++;
            at_step = (m_fade_cycles % STEP_DIV) == 0;
            if (at_step)
                for (int i = 0; i < NCOLORS; i++)
                    m_disp[i] = toward(m_disp[i], m_tbl[m_target][i]);
            if (lvl != m_target) begin
                m_target = lvl;
            end else if (at_step) begin
                done = 1'b1;
                for (int i = 0; i < NCOLORS; i++)
                    if (m_disp[i] != m_tbl[m_target][i]) done = 1'b0;
                if (done) begin
                    m_cur = m_target;
                    m_busy = 1'b0;
                end
            end
        end
        if (bus.WR_EN) m_tbl[bus.WR_LEVEL][bus.WR_INDEX] = bus.WR_DATA;
    endtask

    always begin
        @(posedge CLK or negedge RESET_N);
        if (!RESET_N) model_reset();
        else          model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always begin
        @(negedge CLK);
        if (cmp_en) begin
            check("busy", 32'(bus.BUSY), 32'(m_busy));
            check("cur_level", 32'(bus.CUR_LEVEL), m_cur);
            for (int i = 0; i < NCOLORS; i++)
                check($sformatf("colors[%0d]", i), 32'(bus.COLORS[i*CW +: CW]), 32'(m_disp[i]));
            check("pix_color", 32'(bus.PIX_COLOR), 32'(m_pix));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (bus.BUSY && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(bus.BUSY), 32'd0);
    endtask

    function automatic logic [11:0] color(input int i);
        return bus.COLORS[i*CW +: CW];
    endfunction

    initial begin
        int n;
        bus.LEVEL = '0; bus.FADE_EN = 1'b0; bus.WR_EN = 1'b0;
        bus.WR_LEVEL = '0; bus.WR_INDEX = '0; bus.WR_DATA = '0; bus.PIX_INDEX = '0;
        #1 RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;

        // Reset state
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_cur", 32'(bus.CUR_LEVEL), 32'd0);
        check("rst_c0", 32'(color(0)), 32'h4cf);
        check("rst_c1", 32'(color(1)), 32'h05f);
        check("rst_c2", 32'(color(2)), 32'h000);
        check("rst_c3", 32'(color(3)), 32'hfff);
        check("rst_pix", 32'(bus.PIX_COLOR), 32'h000);
        cmp_en = 1'b1;
        tick();

        // Immediate switch to level 6
        bus.FADE_EN = 1'b0; bus.LEVEL = 3'd6;
        tick();
        check("snap_c0", 32'(color(0)), 32'hf30);
        check("snap_c1", 32'(color(1)), 32'h888);
        check("snap_cur", 32'(bus.CUR_LEVEL), 32'd6);
        check("snap_busy", 32'(bus.BUSY), 32'd0);
        bus.LEVEL = 3'd0;
        tick();

        // Live write to the committed level shows one cycle later
        bus.WR_EN = 1'b1; bus.WR_LEVEL = 3'd0; bus.WR_INDEX = 2'd2;
        bus.WR_DATA = 12'h123; bus.PIX_INDEX = 2'd2;
        tick();
        bus.WR_EN = 1'b0;
        tick();
        check("wr_c2", 32'(color(2)), 32'h123);
        tick();
        check("wr_pix", 32'(bus.PIX_COLOR), 32'h123);

        // Fade 0 -> 1: blue of colour 0 travels 15 units, 4 cycles each
        bus.FADE_EN = 1'b1; bus.LEVEL = 3'd1;
        tick();
        check("fade1_busy", 32'(bus.BUSY), 32'd1);
        wait_idle(200, n);
        check("fade1_len", n, 32'd60);
        check("fade1_c0", 32'(color(0)), 32'h8d0);
        check("fade1_cur", 32'(bus.CUR_LEVEL), 32'd1);

        // Fade 0 -> 1 retargeted to 2; after two steps 4cf has become 6dd
        bus.FADE_EN = 1'b0; bus.LEVEL = 3'd0;
        tick();
        bus.FADE_EN = 1'b1; bus.LEVEL = 3'd1;
        tick();
        repeat (8) tick();
        check("ret_c0_mid", 32'(color(0)), 32'h6dd);
        tick();
        bus.LEVEL = 3'd2;
        // Colour 1 sits at 07d and needs 14 more steps toward e0d.
        wait_idle(200, n);
        check("ret_len", n, 32'd55);
        check("ret_cur", 32'(bus.CUR_LEVEL), 32'd2);
        check("ret_c0", 32'(color(0)), 32'hf7f);
        check("ret_c1", 32'(color(1)), 32'he0d);

        // Fade 2 -> 3 while the target palette is rewritten
        bus.LEVEL = 3'd3;
        tick();
        repeat (5) tick();
        bus.WR_EN = 1'b1; bus.WR_LEVEL = 3'd3; bus.WR_INDEX = 2'd0; bus.WR_DATA = 12'h000;
        tick();
        bus.WR_EN = 1'b0;
        wait_idle(200, n);
        check("live_cur", 32'(bus.CUR_LEVEL), 32'd3);
        check("live_c0", 32'(color(0)), 32'h000);

        // Fade 3 -> 2 abandoned by returning to 3: fades back
        bus.LEVEL = 3'd2;
        tick();
        repeat (6) tick();
        bus.LEVEL = 3'd3;
        wait_idle(200, n);
        check("back_cur", 32'(bus.CUR_LEVEL), 32'd3);
        check("back_c0", 32'(color(0)), 32'h000);
        check("back_c1", 32'(color(1)), 32'h06f);

        // Fade 3 -> 4 cut short by dropping FADE_EN
        bus.LEVEL = 3'd4;
        tick();
        repeat (5) tick();
        bus.FADE_EN = 1'b0;
        tick();
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_cur", 32'(bus.CUR_LEVEL), 32'd4);
        check("abort_c0", 32'(color(0)), 32'h6fa);
        check("abort_c1", 32'(color(1)), 32'hf06);

        // Reset in the middle of a fade 4 -> 5
        bus.FADE_EN = 1'b1; bus.LEVEL = 3'd5;
        tick();
        repeat (6) tick();
        RESET_N = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.BUSY), 32'd0);
        check("mrst_cur", 32'(bus.CUR_LEVEL), 32'd0);
        check("mrst_c0", 32'(color(0)), 32'h4cf);
        check("mrst_c2", 32'(color(2)), 32'h000);
        check("mrst_pix", 32'(bus.PIX_COLOR), 32'h000);
        bus.LEVEL = 3'd0; bus.FADE_EN = 1'b0;
        tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        // Pre-reset table write to level 3 is gone
        bus.LEVEL = 3'd3;
        tick();
        check("mrst_tbl3", 32'(color(0)), 32'h6e6);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
